// File: rtl/aes_core_arbiter_pkg.sv
// rtl/aes_core_arbiter_pkg.sv - shared types and constants for the AES core arbiter
package aes_core_arbiter_pkg;

  localparam int AES_KEY_W              = 128;
  localparam int AES_BLK_W              = 128;
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/aes_core_arbiter_rr_arb2.sv
// rtl/aes_core_arbiter_rr_arb2.sv - two-way round-robin grant, pointer moves only on accept
module aes_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // prio_q set means requester 1 wins the next tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt    = req;
    prio_d = prio_q;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
    if (accept) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - shares one AES-128 core between two requesters
// One transaction in flight: accept, load strobe, wait for done or timeout, hold response.
module aes_core_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_KEY_W-1:0] req0_key,
  input  logic [AES_BLK_W-1:0] req0_text,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_KEY_W-1:0] req1_key,
  input  logic [AES_BLK_W-1:0] req1_text,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [AES_BLK_W-1:0] resp0_data,
  output logic                 resp0_err,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [AES_BLK_W-1:0] resp1_data,
  output logic                 resp1_err,
  output logic                 core_ld,
  output logic [AES_KEY_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_text_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 gid_q, gid_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] text_q, text_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] data_q, data_d;
  logic                 err_q, err_d;

  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       accept;
  logic       resp_ready_g;
  logic       resp_active;

  assign req_vec      = {req1_valid, req0_valid};
  assign accept       = (state_q == ST_IDLE) && (req_vec != 2'b00);
  assign resp_ready_g = gid_q ? resp1_ready : resp0_ready;

  aes_rr_arb2 u_rr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    key_d   = key_q;
    text_d  = text_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          gid_d   = gnt[1];
          key_d   = gnt[1] ? req1_key  : req0_key;
          text_d  = gnt[1] ? req1_text : req0_text;
        end
      end
      ST_LOAD: begin
        state_d = ST_BUSY;
        cnt_d   = '0;
      end
      ST_BUSY: begin
        // done in the final counted cycle still beats the timeout
        if (core_done) begin
          state_d = ST_RESP;
          data_d  = core_text_out;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready_g) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gid_q   <= 1'b0;
      key_q   <= '0;
      text_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      key_q   <= key_d;
      text_q  <= text_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign resp_active  = (state_q == ST_RESP);
  assign req0_ready   = accept && gnt[0];
  assign req1_ready   = accept && gnt[1];
  assign resp0_valid  = resp_active && !gid_q;
  assign resp1_valid  = resp_active && gid_q;
  assign resp0_data   = resp0_valid ? data_q : '0;
  assign resp1_data   = resp1_valid ? data_q : '0;
  assign resp0_err    = resp0_valid && err_q;
  assign resp1_err    = resp1_valid && err_q;
  assign core_ld      = (state_q == ST_LOAD);
  assign core_key     = key_q;
  assign core_text_in = text_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - randomized bench with transaction-timeline reference model
module tb_aes_core_arbiter;
  import aes_core_arbiter_pkg::*;

  localparam int TO_A = TIMEOUT_CYCLES_DEFAULT;
  localparam int TO_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel;
  logic [1:0]   in_valid, in_rready;
  logic [127:0] in_key [2];
  logic [127:0] in_text [2];
  logic         in_done;
  logic [127:0] in_tout;

  logic a_rdy0, a_rdy1, a_rv0, a_rv1, a_er0, a_er1, a_ld;
  logic [127:0] a_d0, a_d1, a_k, a_t;
  logic b_rdy0, b_rdy1, b_rv0, b_rv1, b_er0, b_er1, b_ld;
  logic [127:0] b_d0, b_d1, b_k, b_t;

  aes_core_arbiter #(.TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(in_valid[0] & ~sel), .req0_ready(a_rdy0), .req0_key(in_key[0]), .req0_text(in_text[0]),
    .req1_valid(in_valid[1] & ~sel), .req1_ready(a_rdy1), .req1_key(in_key[1]), .req1_text(in_text[1]),
    .resp0_valid(a_rv0), .resp0_ready(in_rready[0]), .resp0_data(a_d0), .resp0_err(a_er0),
    .resp1_valid(a_rv1), .resp1_ready(in_rready[1]), .resp1_data(a_d1), .resp1_err(a_er1),
    .core_ld(a_ld), .core_key(a_k), .core_text_in(a_t),
    .core_done(in_done & ~sel), .core_text_out(in_tout)
  );

  aes_core_arbiter #(.TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(in_valid[0] & sel), .req0_ready(b_rdy0), .req0_key(in_key[0]), .req0_text(in_text[0]),
    .req1_valid(in_valid[1] & sel), .req1_ready(b_rdy1), .req1_key(in_key[1]), .req1_text(in_text[1]),
    .resp0_valid(b_rv0), .resp0_ready(in_rready[0]), .resp0_data(b_d0), .resp0_err(b_er0),
    .resp1_valid(b_rv1), .resp1_ready(in_rready[1]), .resp1_data(b_d1), .resp1_err(b_er1),
    .core_ld(b_ld), .core_key(b_k), .core_text_in(b_t),
    .core_done(in_done & sel), .core_text_out(in_tout)
  );

  logic [1:0]   o_ready, o_rv, o_err;
  logic [127:0] o_data [2];
  logic         o_ld, other_busy;
  logic [127:0] o_key, o_text;

  always_comb begin
    if (sel) begin
      o_ready = {b_rdy1, b_rdy0}; o_rv = {b_rv1, b_rv0}; o_err = {b_er1, b_er0};
      o_data[0] = b_d0; o_data[1] = b_d1; o_ld = b_ld; o_key = b_k; o_text = b_t;
      other_busy = a_rdy0 | a_rdy1 | a_rv0 | a_rv1 | a_er0 | a_er1 | a_ld | (|a_d0) | (|a_d1);
    end else begin
      o_ready = {a_rdy1, a_rdy0}; o_rv = {a_rv1, a_rv0}; o_err = {a_er1, a_er0};
      o_data[0] = a_d0; o_data[1] = a_d1; o_ld = a_ld; o_key = a_k; o_text = a_t;
      other_busy = b_rdy0 | b_rdy1 | b_rv0 | b_rv1 | b_er0 | b_er1 | b_ld | (|b_d0) | (|b_d1);
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: one transaction described by its accept cycle and response cycle
  bit           m_busy = 1'b0;
  int           m_owner, m_acc, m_resp_at;
  int           m_last [2] = '{1, 1};
  logic [127:0] m_key, m_text, m_data;
  logic         m_err;
  int           acc_log [$];

  bit  pend [2] = '{1'b0, 1'b0};
  bit  auto_req = 1'b0, rdy_rand = 1'b0, rdy_low = 1'b0, spur_en = 1'b0, force_done = 1'b0, lat_rand = 1'b0;
  int  lat_fix = 3, done_cyc = -1;
  logic [127:0] ck, ct;

  int  ld_count, obs_ld_cyc, obs_rv_cyc, obs_hs_cyc, obs_rdy_cyc;
  logic [127:0] obs_data;
  logic obs_err;

  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
    return k ^ (t << 1);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clr_obs();
    ld_count = 0; obs_ld_cyc = -1; obs_rv_cyc = -1; obs_hs_cyc = -1; obs_rdy_cyc = -1;
    obs_data = '0; obs_err = 1'b0;
  endtask

  function automatic int rand_lat();
    if (sel) return int'($urandom_range(1, 11));
    if ($urandom_range(15) == 0) return -1;
    return int'($urandom_range(1, 20));
  endfunction

  task automatic step();
    int g;
    logic [1:0] e_ready, e_rv, e_err;
    logic e_ld;
    logic [127:0] e_d [2];
    for (int n = 0; n < 2; n++) begin
      if (auto_req && !pend[n] && $urandom_range(99) < 25) begin
        pend[n] = 1'b1;
        in_key[n] = {$urandom, $urandom, $urandom, $urandom};
        in_text[n] = {$urandom, $urandom, $urandom, $urandom};
      end
      in_valid[n] = rst & pend[n];
      in_rready[n] = rdy_low ? 1'b0 : (rdy_rand ? ($urandom_range(99) < 70) : 1'b1);
    end
    in_done = force_done | (cyc == done_cyc) | (spur_en && $urandom_range(19) == 0);
    in_tout = (cyc == done_cyc) ? cipher(ck, ct) : {$urandom, $urandom, $urandom, $urandom};

    @(negedge clk);
    if (!rst) begin
      m_busy = 1'b0; m_last[0] = 1; m_last[1] = 1;
    end
    e_ready = '0; e_rv = '0; e_err = '0; e_ld = 1'b0; e_d[0] = '0; e_d[1] = '0; g = -1;
    if (!m_busy) begin
      if (in_valid == 2'b11) g = (m_last[sel] == 0) ? 1 : 0;
      else if (in_valid[0]) g = 0;
      else if (in_valid[1]) g = 1;
      if (g >= 0) e_ready[g] = 1'b1;
    end else begin
      e_ld = (cyc == m_acc + 1);
      if (m_resp_at >= 0 && cyc >= m_resp_at) begin
        e_rv[m_owner] = 1'b1; e_d[m_owner] = m_data; e_err[m_owner] = m_err;
      end
    end
    for (int n = 0; n < 2; n++) begin
      chk1($sformatf("req%0d_ready", n), o_ready[n], e_ready[n]);
      chk1($sformatf("resp%0d_valid", n), o_rv[n], e_rv[n]);
      chk128($sformatf("resp%0d_data", n), o_data[n], e_d[n]);
      chk1($sformatf("resp%0d_err", n), o_err[n], e_err[n]);
    end
    chk1("core_ld", o_ld, e_ld);
    if (m_busy && cyc >= m_acc + 1) begin
      chk128("core_key", o_key, m_key);
      chk128("core_text_in", o_text, m_text);
    end else if (!rst) begin
      chk128("core_key_rst", o_key, '0);
      chk128("core_text_rst", o_text, '0);
    end
    chk1("other_dut_quiet", other_busy, 1'b0);

    if (o_ld) begin
      ld_count++; obs_ld_cyc = cyc; ck = o_key; ct = o_text;
      lat_fix = lat_rand ? rand_lat() : lat_fix;
      done_cyc = (lat_fix < 0) ? -1 : cyc + lat_fix;
    end
    if (o_rv != 2'b00 && obs_rv_cyc < 0) begin
      obs_rv_cyc = cyc;
      obs_data = o_rv[1] ? o_data[1] : o_data[0];
      obs_err = o_rv[1] ? o_err[1] : o_err[0];
    end
    if ((o_rv & in_rready) != 2'b00 && obs_hs_cyc < 0) obs_hs_cyc = cyc;
    if (o_ready != 2'b00) obs_rdy_cyc = cyc;

    if (rst) begin
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1'b1; m_owner = g; m_acc = cyc; m_resp_at = -1;
          m_key = in_key[g]; m_text = in_text[g]; m_last[sel] = g;
          pend[g] = 1'b0; acc_log.push_back(g);
        end
      end else if (m_resp_at < 0) begin
        if (cyc >= m_acc + 2) begin
          if (in_done) begin
            m_resp_at = cyc + 1; m_data = in_tout; m_err = 1'b0;
          end else if (cyc - m_acc - 2 == (sel ? TO_B : TO_A) - 1) begin
            m_resp_at = cyc + 1; m_data = '0; m_err = 1'b1;
          end
        end
      end else if (in_rready[m_owner]) begin
        m_busy = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int max, input string name);
    int i = 0;
    do begin
      step();
      i++;
    end while ((m_busy || pend[0] || pend[1]) && i < max);
    total++;
    if (m_busy || pend[0] || pend[1]) begin
      bad++;
      $display("FAIL %s cycle budget %0d expired before idle", name, max);
    end
  endtask

  task automatic wait_rv(input int max, input string name);
    int i = 0;
    while (obs_rv_cyc < 0 && i < max) begin
      step();
      i++;
    end
    chki({name, "_resp_seen"}, (obs_rv_cyc >= 0) ? 1 : 0, 1);
  endtask

  task automatic load(input int n, input logic [127:0] k, input logic [127:0] t);
    in_key[n] = k; in_text[n] = t; pend[n] = 1'b1;
  endtask

  int exp_alt [4] = '{0, 1, 0, 1};
  logic [127:0] held;

  initial begin
    rst = 1'b0; sel = 1'b0; in_valid = '0; in_rready = '0; in_done = 1'b0; in_tout = '0;
    in_key[0] = '0; in_key[1] = '0; in_text[0] = '0; in_text[1] = '0;
    ck = '0; ct = '0;
    clr_obs();
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 1'b1;
    step();

    // single transaction, core finishes 12 cycles after the load strobe
    clr_obs(); lat_fix = 12;
    load(0, 128'd107, 128'd100);
    run_until_idle(100, "single");
    chki("single_ld_count", ld_count, 1);
    chki("single_ld_latency", obs_ld_cyc - obs_rdy_cyc, 1);
    chki("single_resp_latency", obs_rv_cyc - obs_ld_cyc, 13);
    chk128("single_data", obs_data, 128'd163);
    chk1("single_err", obs_err, 1'b0);

    // contention straight after reset alternates 0,1,0,1
    rst = 1'b0; step(); step(); rst = 1'b1;
    acc_log.delete(); lat_fix = 3;
    load(0, 128'h11, 128'h22); load(1, 128'h33, 128'h44);
    run_until_idle(100, "contend_a");
    load(0, 128'h55, 128'h66); load(1, 128'h77, 128'h88);
    run_until_idle(100, "contend_b");
    chki("contend_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chki($sformatf("contend_order%0d", i), acc_log[i], exp_alt[i]);

    // backpressure on resp0 with req1 waiting
    clr_obs(); lat_fix = 4; rdy_low = 1'b1;
    load(0, 128'hA5, 128'h5A);
    wait_rv(40, "bp");
    load(1, 128'hC3, 128'h3C);
    held = obs_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_valid_held", o_rv[0], 1'b1);
      chk128("bp_data_held", o_data[0], held);
    end
    chki("bp_no_accept", (obs_rdy_cyc < obs_rv_cyc) ? 1 : 0, 1);
    rdy_low = 1'b0;
    run_until_idle(60, "bp_drain");
    chki("bp_next_accept", obs_rdy_cyc - obs_hs_cyc, 1);

    // spurious done while idle, then while a response is held
    clr_obs(); force_done = 1'b1; step(); force_done = 1'b0; step(); step();
    chki("spur_idle_ld", ld_count, 0);
    chki("spur_idle_resp", obs_rv_cyc, -1);
    lat_fix = 3; rdy_low = 1'b1;
    load(0, 128'h9, 128'h7);
    wait_rv(40, "spur");
    held = obs_data;
    force_done = 1'b1; step(); force_done = 1'b0; step();
    chk128("spur_resp_data", o_data[0], held);
    chk128("spur_resp_value", held, cipher(128'h9, 128'h7));
    rdy_low = 1'b0;
    run_until_idle(40, "spur_drain");

    // reset while the core is busy; its late done must be dropped
    clr_obs(); lat_fix = 10;
    load(1, 128'hDEAD, 128'hBEEF);
    for (int i = 0; i < 20 && obs_ld_cyc < 0; i++) step();
    step(); step();
    rst = 1'b0; step(); step(); rst = 1'b1;
    obs_rv_cyc = -1;
    repeat (15) step();
    chki("rst_no_resp", obs_rv_cyc, -1);
    clr_obs(); lat_fix = 3;
    load(0, 128'h1234, 128'h5678);
    run_until_idle(40, "rst_after");
    chki("rst_after_latency", obs_rv_cyc - obs_ld_cyc, 4);
    chk1("rst_after_err", obs_err, 1'b0);

    // timeout variant with TIMEOUT_CYCLES=8
    sel = 1'b1;
    clr_obs(); lat_fix = -1;
    load(0, 128'h5, 128'h9);
    run_until_idle(60, "timeout");
    chki("timeout_latency", obs_rv_cyc - obs_ld_cyc, 9);
    chk128("timeout_data", obs_data, '0);
    chk1("timeout_err", obs_err, 1'b1);
    clr_obs(); lat_fix = 8;
    load(1, 128'h5, 128'h9);
    run_until_idle(60, "done_last");
    chki("done_last_latency", obs_rv_cyc - obs_ld_cyc, 9);
    chk128("done_last_data", obs_data, 128'd23);
    chk1("done_last_err", obs_err, 1'b0);

    // randomized traffic on both variants
    for (int s = 1; s >= 0; s--) begin
      sel = s[0];
      auto_req = 1'b1; rdy_rand = 1'b1; spur_en = 1'b1; lat_rand = 1'b1;
      repeat (1500) step();
      auto_req = 1'b0; spur_en = 1'b0; rdy_rand = 1'b0;
      run_until_idle(400, "random_drain");
      lat_rand = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum BUSY cycles to wait for core_done before an error response is issued.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N has a key/text pair to process.
REQ-005 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's pair in this cycle.
REQ-006 reqN_key  input  128  (N=0,1) AES-128 key from requester N.
REQ-007 reqN_text  input  128  (N=0,1) plaintext from requester N.
REQ-008 respN_valid  output  1  (N=0,1) result for requester N is present.
REQ-009 respN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-010 respN_data  output  128  (N=0,1) ciphertext for requester N.
REQ-011 respN_err  output  1  (N=0,1) result is a timeout error.
REQ-012 core_ld  output  1  one-cycle load strobe to the shared AES core.
REQ-013 core_key  output  128  key to the core; stable from core_ld until transaction end.
REQ-014 core_text_in  output  128  text to the core; same stability as core_key.
REQ-015 core_done  input  1  core completion pulse.
REQ-016 core_text_out  input  128  core result; valid in the core_done cycle.

Function
REQ-017 FSM states IDLE, LOAD, BUSY, RESP; exactly one transaction in flight.
REQ-018 IDLE: if any reqN_valid, grant one, assert its reqN_ready for that one cycle only, latch key/text and grant ID, go to LOAD; else stay.
REQ-019 Arbitration round-robin: both valid -> grant requester not granted last; pointer updates only on accept; after reset req0 wins first tie.
REQ-020 reqN_ready SHALL never be asserted outside IDLE or for the non-granted requester.
REQ-021 LOAD: core_ld=1 for exactly one cycle, core_key/core_text_in driven from latches; go to BUSY; timeout counter cleared.
REQ-022 BUSY: core_done sampled only here; on core_done latch core_text_out to granted respN_data, err=0, go to RESP.
REQ-023 BUSY: counter increments each cycle without done; at count TIMEOUT_CYCLES-1 without done -> respN_data=0, err=1, go to RESP; done in that same cycle wins (normal result).
REQ-024 core_done in IDLE, LOAD or RESP SHALL be ignored.
REQ-025 RESP: granted respN_valid held high with data/err stable until respN_ready; on handshake deassert next cycle, go to IDLE.
REQ-026 Latency: accept at cycle T -> core_ld at T+1 -> BUSY from T+2; done at cycle D -> resp valid at D+1; earliest next accept one cycle after resp handshake.
REQ-027 Non-granted resp outputs stay 0 (valid, data, err) at all times.
REQ-028 Requesters hold valid and payload until ready; arbiter samples payload only in accept cycle.

Reset
REQ-029 rst low asynchronously forces IDLE, all outputs 0, latches 0, timeout counter 0, RR pointer to favour req0.
REQ-030 Reset mid-transaction discards it: no resp issued after release, core_ld low, late core_done ignored.

Structure
REQ-031 Shared package holds FSM state enum, AES_KEY_W=128, AES_BLK_W=128, and default TIMEOUT_CYCLES.
REQ-032 One sub-module natural: aes_rr_arb2 (2-way round-robin grant with pointer update on accept); rest in single top.

Verification
REQ-033 Single: req0 key=128'd107 text=128'd100, core model done 12 cycles after ld -> one core_ld, resp0_valid with model ciphertext, err=0, resp1 silent.
REQ-034 Contention: req0,req1 valid same cycle after reset -> req0 served first, req1 second; repeat -> alternation 0,1,0,1.
REQ-035 Backpressure: resp0_ready low 5 cycles -> resp0_valid/data stable 5 cycles, no new accept until handshake.
REQ-036 Timeout: TIMEOUT_CYCLES=8, core never done -> resp valid exactly 8 cycles after BUSY entry, data=0, err=1; done at count 7 -> normal result.
REQ-037 Spurious done: core_done pulsed in IDLE and RESP -> no state/output change.
REQ-038 Reset mid-BUSY: rst low 2 cycles then high, core_done arrives -> no resp, FSM IDLE, next request normal.
